// File: rtl/brush_stamper_if.sv
// Frame-buffer write port: one pixel request held until the arbiter acknowledges it.
interface brush_stamper_if;
    logic       wr_req;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic [7:0] wr_data;
    logic       wr_ack;

    modport master (output wr_req, wr_x, wr_y, wr_data, input wr_ack);
    modport slave  (input wr_req, wr_x, wr_y, wr_data, output wr_ack);
endinterface

// File: rtl/brush_stamper.sv
// Latches the cursor on a frame tick and walks the clipped square brush
// row-major, issuing one frame-buffer write per pixel over req/ack.
module brush_stamper #(
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int MAX_SIZE = 15
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_clk,
    input  logic                   pen_down,
    input  logic                   erase,
    input  logic [7:0]             color,
    input  logic [9:0]             BallX,
    input  logic [9:0]             BallY,
    input  logic [9:0]             BallS,
    brush_stamper_if.master        wr,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    typedef enum logic [1:0] {IDLE, CALC, STAMP, DONE} state_t;

    localparam logic signed [11:0] L_XMAX = 12'(X_MAX);
    localparam logic signed [11:0] L_YMAX = 12'(Y_MAX);
    localparam logic [9:0]         L_SMAX = 10'(MAX_SIZE);

    state_t     r_state;
    logic       r_sync0, r_sync1, r_syncPrev;
    logic [9:0] r_cx, r_cy, r_s;
    logic [7:0] r_data;
    logic [9:0] r_x0, r_x1, r_y1;
    logic       r_wrReq;
    logic [9:0] r_wrX, r_wrY;
    logic [7:0] r_wrData;
    logic       r_busy, r_done, r_overrun;
    logic       r_lastValid;
    logic [9:0] r_lastX, r_lastY, r_lastS;
    logic [7:0] r_lastData;

    logic              w_tick;
    logic [9:0]        w_size;
    logic [7:0]        w_data;
    logic              w_dup;
    logic signed [11:0] w_xLo, w_xHi, w_yLo, w_yHi;
    logic signed [11:0] w_x0s, w_x1s, w_y0s, w_y1s;
    logic [9:0]        w_x0, w_x1, w_y0, w_y1;
    logic              w_empty;

    assign w_tick = r_sync1 & ~r_syncPrev;
    assign w_size = (BallS > L_SMAX) ? L_SMAX : BallS;
    assign w_data = erase ? 8'h00 : color;
    assign w_dup  = r_lastValid && (BallX == r_lastX) && (BallY == r_lastY) &&
                    (w_size == r_lastS) && (w_data == r_lastData);

    // Bounds use a 12-bit signed range so cx+s never wraps before clipping.
    assign w_xLo = $signed({2'b00, r_cx}) - $signed({2'b00, r_s});
    assign w_xHi = $signed({2'b00, r_cx}) + $signed({2'b00, r_s});
    assign w_yLo = $signed({2'b00, r_cy}) - $signed({2'b00, r_s});
    assign w_yHi = $signed({2'b00, r_cy}) + $signed({2'b00, r_s});

    assign w_x0s = (w_xLo < 12'sd0) ? 12'sd0 : w_xLo;
    assign w_x1s = (w_xHi > L_XMAX) ? L_XMAX : w_xHi;
    assign w_y0s = (w_yLo < 12'sd0) ? 12'sd0 : w_yLo;
    assign w_y1s = (w_yHi > L_YMAX) ? L_YMAX : w_yHi;

    assign w_x0 = 10'(w_x0s);
    assign w_x1 = 10'(w_x1s);
    assign w_y0 = 10'(w_y0s);
    assign w_y1 = 10'(w_y1s);

    assign w_empty = (w_x0s > w_x1s) || (w_y0s > w_y1s);

    assign wr.wr_req  = r_wrReq;
    assign wr.wr_x    = r_wrX;
    assign wr.wr_y    = r_wrY;
    assign wr.wr_data = r_wrData;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overrun    = r_overrun;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_sync0     <= 1'b0;
            r_sync1     <= 1'b0;
            r_syncPrev  <= 1'b0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_s         <= '0;
            r_data      <= '0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_wrReq     <= 1'b0;
            r_wrX       <= '0;
            r_wrY       <= '0;
            r_wrData    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_lastValid <= 1'b0;
            r_lastX     <= '0;
            r_lastY     <= '0;
            r_lastS     <= '0;
            r_lastData  <= '0;
        end else begin
            r_sync0    <= frame_clk;
            r_sync1    <= r_sync0;
            r_syncPrev <= r_sync1;
            r_done     <= 1'b0;

            if (w_tick && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        if (pen_down) begin
                            r_cx   <= BallX;
                            r_cy   <= BallY;
                            r_s    <= w_size;
                            r_data <= w_data;
                            if (!w_dup) begin
                                r_state <= CALC;
                                r_busy  <= 1'b1;
                            end
                        end else begin
                            r_lastValid <= 1'b0;
                        end
                    end
                end

                CALC: begin
                    r_x0 <= w_x0;
                    r_x1 <= w_x1;
                    r_y1 <= w_y1;
                    if (w_empty) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_wrReq  <= 1'b1;
                        r_wrX    <= w_x0;
                        r_wrY    <= w_y0;
                        r_wrData <= r_data;
                        r_state  <= STAMP;
                    end
                end

                // The request registers double as the pixel cursor.
                STAMP: begin
                    if (wr.wr_ack) begin
                        if (r_wrX < r_x1) begin
                            r_wrX <= r_wrX + 10'd1;
                        end else if (r_wrY < r_y1) begin
                            r_wrX <= r_x0;
                            r_wrY <= r_wrY + 10'd1;
                        end else begin
                            r_wrReq <= 1'b0;
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    r_lastValid <= 1'b1;
                    r_lastX     <= r_cx;
                    r_lastY     <= r_cy;
                    r_lastS     <= r_s;
                    r_lastData  <= r_data;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_wrReq <= 1'b0;
                end
            endcase
        end
    end

endmodule
